pbkdf2_frame_loader: RTL and testbench

Upstream feeder for the PBKDF2 key generator. Accepts a byte-serial request frame from the host byte link and assembles iteration count, salt, salt length and password into the wide parallel fields the generator loads. It presents one complete job at a time on a valid/ready output handshake and rejects malformed frames with a one-cycle error pulse.

---
 rtl/pbkdf2_frame_loader.sv | 158 +++++++++++++++
 tb/tb_pbkdf2_frame_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pbkdf2_frame_loader.sv
// Byte-serial request frame loader for the PBKDF2 key generator.
// Assembles iteration count, salt and password into wide fields behind a valid/ready handshake.
module pbkdf2_frame_loader #(
  parameter int unsigned BLOCK_BYTES    = 64,
  parameter int unsigned MAX_SALT_BYTES = 63,
  parameter int unsigned ITER_BYTES     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               byte_i,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic [31:0]              iters_o,
  output logic [8*BLOCK_BYTES-1:0] pass_o,
  output logic [8*BLOCK_BYTES-1:0] salt_o,
  output logic [5:0]               salt_len_o,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err_o
);

  localparam int unsigned W         = 8 * BLOCK_BYTES;
  localparam logic [7:0]  MaxSaltB  = 8'(MAX_SALT_BYTES);
  localparam logic [7:0]  MaxPassB  = 8'(BLOCK_BYTES);
  localparam logic [6:0]  IterLast  = 7'(ITER_BYTES - 1);

  typedef enum logic [2:0] {StIter, StSlen, StSalt, StPlen, StPass, StOut} state_e;

  state_e       state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [6:0]   pass_len_q, pass_len_d;
  logic [31:0]  iters_q, iters_d;
  logic [W-1:0] pass_q, pass_d;
  logic [W-1:0] salt_q, salt_d;
  logic [5:0]   salt_len_q, salt_len_d;
  logic         err_q, err_d;
  logic         accept;

  assign byte_ready = (state_q != StOut);
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pass_len_d = pass_len_q;
    iters_d    = iters_q;
    pass_d     = pass_q;
    salt_d     = salt_q;
    salt_len_d = salt_len_q;
    err_d      = 1'b0;

    unique case (state_q)
      StIter: if (accept) begin
        if (cnt_q == 7'd0) begin
          // First byte of a frame wipes every field so a shorter frame never shows stale bytes
          iters_d    = 32'(byte_i);
          pass_d     = '0;
          salt_d     = '0;
          salt_len_d = '0;
          pass_len_d = '0;
        end else begin
          iters_d = {iters_q[23:0], byte_i};
        end
        if (cnt_q == IterLast) begin
          cnt_d   = '0;
          state_d = StSlen;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StSlen: if (accept) begin
        if (byte_i > MaxSaltB) begin
          err_d   = 1'b1;
          state_d = StIter;
        end else begin
          salt_len_d = byte_i[5:0];
          state_d    = (byte_i == 8'd0) ? StPlen : StSalt;
        end
      end
      StSalt: if (accept) begin
        for (int k = 0; k < BLOCK_BYTES; k++) begin
          if (cnt_q == 7'(k)) salt_d[8*(BLOCK_BYTES-1-k) +: 8] = byte_i;
        end
        if (cnt_q == {1'b0, salt_len_q} - 7'd1) begin
          cnt_d   = '0;
          state_d = StPlen;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StPlen: if (accept) begin
        if (byte_i > MaxPassB) begin
          err_d   = 1'b1;
          state_d = StIter;
        end else begin
          pass_len_d = byte_i[6:0];
          if (byte_i != 8'd0) begin
            state_d = StPass;
          end else if (iters_q == 32'd0) begin
            err_d   = 1'b1;
            state_d = StIter;
          end else begin
            state_d = StOut;
          end
        end
      end
      StPass: if (accept) begin
        for (int k = 0; k < BLOCK_BYTES; k++) begin
          if (cnt_q == 7'(k)) pass_d[8*(BLOCK_BYTES-1-k) +: 8] = byte_i;
        end
        if (cnt_q == pass_len_q - 7'd1) begin
          cnt_d = '0;
          // A zero iteration count is only rejected once the whole frame is consumed
          if (iters_q == 32'd0) begin
            err_d   = 1'b1;
            state_d = StIter;
          end else begin
            state_d = StOut;
          end
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StOut: if (out_ready) state_d = StIter;
      default: state_d = StIter;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIter;
      cnt_q      <= '0;
      pass_len_q <= '0;
      iters_q    <= '0;
      pass_q     <= '0;
      salt_q     <= '0;
      salt_len_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pass_len_q <= pass_len_d;
      iters_q    <= iters_d;
      pass_q     <= pass_d;
      salt_q     <= salt_d;
      salt_len_q <= salt_len_d;
      err_q      <= err_d;
    end
  end

  assign iters_o    = iters_q;
  assign pass_o     = pass_q;
  assign salt_o     = salt_q;
  assign salt_len_o = salt_len_q;
  assign out_valid  = (state_q == StOut);
  assign err_o      = err_q;

endmodule

// File: tb/tb_pbkdf2_frame_loader.sv
// Directed bench for pbkdf2_frame_loader: table of frames plus hand sequences for
// the 64-byte password, byte_valid gaps with leakage check, and async reset mid-frame.
module tb_pbkdf2_frame_loader;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [7:0]   byte_i;
  logic         byte_valid;
  logic         byte_ready;
  logic [31:0]  iters_o;
  logic [511:0] pass_o;
  logic [511:0] salt_o;
  logic [5:0]   salt_len_o;
  logic         out_valid;
  logic         out_ready;
  logic         err_o;

  int checks   = 0;
  int failures = 0;

  pbkdf2_frame_loader dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .byte_i     (byte_i),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .iters_o    (iters_o),
    .pass_o     (pass_o),
    .salt_o     (salt_o),
    .salt_len_o (salt_len_o),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] iters;
    int unsigned slen;
    logic [63:0] salt;
    int unsigned plen;
    logic [63:0] pass;
    logic        exp_err;
    logic [31:0] exp_iters;
    logic [5:0]  exp_slen;
    logic [63:0] exp_salt_hi;
    logic [63:0] exp_pass_hi;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every task starts and ends 1 time unit after a rising clock edge.
  task automatic send_byte(input logic [7:0] b, input int unsigned maxgap);
    int n;
    int unsigned gap;
    gap = (maxgap == 0) ? 0 : $urandom_range(maxgap, 0);
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk_i);
      #1;
    end
    byte_i     = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (n == 20) chk("byte_ready timeout", 512'(byte_ready), 512'(1));
    @(posedge clk_i);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v, input int unsigned maxgap);
    logic [31:0] it;
    logic [63:0] t;
    it = v.iters;
    for (int i = 0; i < 4; i++) begin
      send_byte(it[31:24], maxgap);
      it = it << 8;
    end
    send_byte(8'(v.slen), maxgap);
    if (v.slen > 63) return;
    t = v.salt;
    for (int i = 0; i < int'(v.slen); i++) begin
      send_byte(t[63:56], maxgap);
      t = t << 8;
    end
    send_byte(8'(v.plen), maxgap);
    if (v.plen > 64) return;
    t = v.pass;
    for (int i = 0; i < int'(v.plen); i++) begin
      send_byte(t[63:56], maxgap);
      t = t << 8;
    end
  endtask

  task automatic check_fields(input string tag, input logic [31:0] it, input logic [5:0] sl,
                              input logic [511:0] salt, input logic [511:0] pass);
    chk({tag, " iters_o"}, 512'(iters_o), 512'(it));
    chk({tag, " salt_len_o"}, 512'(salt_len_o), 512'(sl));
    chk({tag, " salt_o"}, salt_o, salt);
    chk({tag, " pass_o"}, pass_o, pass);
  endtask

  task automatic release_job(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i);
      #1;
      chk({tag, " out_valid held"}, 512'(out_valid), 512'(1));
      chk({tag, " byte_ready low in out"}, 512'(byte_ready), 512'(0));
    end
    out_ready = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, 512'(out_valid), 512'(0));
    chk({tag, " byte_ready after job"}, 512'(byte_ready), 512'(1));
  endtask

  task automatic check_vec(input string tag, input vec_t v, input int hold);
    chk({tag, " err_o"}, 512'(err_o), 512'(v.exp_err));
    chk({tag, " out_valid"}, 512'(out_valid), 512'(!v.exp_err));
    if (v.exp_err) begin
      @(posedge clk_i);
      #1;
      chk({tag, " err_o single pulse"}, 512'(err_o), 512'(0));
      chk({tag, " out_valid after err"}, 512'(out_valid), 512'(0));
    end else begin
      check_fields(tag, v.exp_iters, v.exp_slen, {v.exp_salt_hi, 448'd0},
                   {v.exp_pass_hi, 448'd0});
      release_job(tag, hold);
    end
  endtask

  initial begin
    vec_t         v2;
    logic [511:0] exp_pass;

    rst_i      = 1'b1;
    byte_i     = 8'd0;
    byte_valid = 1'b0;
    out_ready  = 1'b0;

    vecs[0] = '{iters: 32'h0000_1000, slen: 4, salt: 64'h7361_6C74_0000_0000, plen: 8,
                pass: 64'h7061_7373_776F_7264, exp_err: 1'b0, exp_iters: 32'h0000_1000,
                exp_slen: 6'd4, exp_salt_hi: 64'h7361_6C74_0000_0000,
                exp_pass_hi: 64'h7061_7373_776F_7264};
    vecs[1] = '{iters: 32'h0000_0010, slen: 64, salt: 64'd0, plen: 0, pass: 64'd0,
                exp_err: 1'b1, exp_iters: 32'd0, exp_slen: 6'd0, exp_salt_hi: 64'd0,
                exp_pass_hi: 64'd0};
    vecs[2] = '{iters: 32'h0000_0000, slen: 1, salt: 64'hAA00_0000_0000_0000, plen: 1,
                pass: 64'h5500_0000_0000_0000, exp_err: 1'b1, exp_iters: 32'd0,
                exp_slen: 6'd0, exp_salt_hi: 64'd0, exp_pass_hi: 64'd0};
    vecs[3] = '{iters: 32'h0000_0001, slen: 0, salt: 64'd0, plen: 65, pass: 64'd0,
                exp_err: 1'b1, exp_iters: 32'd0, exp_slen: 6'd0, exp_salt_hi: 64'd0,
                exp_pass_hi: 64'd0};
    vecs[4] = '{iters: 32'hDEAD_BEEF, slen: 1, salt: 64'hAA00_0000_0000_0000, plen: 0,
                pass: 64'd0, exp_err: 1'b0, exp_iters: 32'hDEAD_BEEF, exp_slen: 6'd1,
                exp_salt_hi: 64'hAA00_0000_0000_0000, exp_pass_hi: 64'd0};
    vecs[5] = '{iters: 32'h0102_0304, slen: 8, salt: 64'h0102_0304_0506_0708, plen: 1,
                pass: 64'hFF00_0000_0000_0000, exp_err: 1'b0, exp_iters: 32'h0102_0304,
                exp_slen: 6'd8, exp_salt_hi: 64'h0102_0304_0506_0708,
                exp_pass_hi: 64'hFF00_0000_0000_0000};

    #2;
    check_fields("reset", 32'd0, 6'd0, 512'd0, 512'd0);
    chk("reset out_valid", 512'(out_valid), 512'(0));
    chk("reset err_o", 512'(err_o), 512'(0));
    chk("reset byte_ready", 512'(byte_ready), 512'(1));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      send_vec(vecs[i], 0);
      check_vec($sformatf("vec%0d", i), vecs[i], (i == 0) ? 10 : 2);
    end

    // Empty salt, full 64-byte password 0x01..0x40
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h40, 0);
    for (int k = 1; k <= 64; k++) send_byte(8'(k), 0);
    exp_pass = '0;
    for (int k = 1; k <= 64; k++) exp_pass[8*(64-k) +: 8] = 8'(k);
    chk("pass64 out_valid", 512'(out_valid), 512'(1));
    check_fields("pass64", 32'd1, 6'd0, 512'd0, exp_pass);
    chk("pass64 last byte", 512'(pass_o[7:0]), 512'(8'h40));
    chk("pass64 first byte", 512'(pass_o[511:504]), 512'(8'h01));
    release_job("pass64", 1);

    // Random byte_valid gaps, then a 1-byte salt frame after the 4-byte salt one
    send_vec(vecs[0], 3);
    check_vec("gaps", vecs[0], 1);
    v2 = '{iters: 32'h0000_0002, slen: 1, salt: 64'hAA00_0000_0000_0000, plen: 1,
           pass: 64'h5500_0000_0000_0000, exp_err: 1'b0, exp_iters: 32'h0000_0002,
           exp_slen: 6'd1, exp_salt_hi: 64'hAA00_0000_0000_0000,
           exp_pass_hi: 64'h5500_0000_0000_0000};
    send_vec(v2, 2);
    chk("noleak salt tail", 512'(salt_o[503:0]), 512'd0);
    chk("noleak pass tail", 512'(pass_o[503:0]), 512'd0);
    check_vec("noleak", v2, 1);

    // Asynchronous reset in the middle of the salt
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    send_byte(8'h04, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #3;
    rst_i = 1'b1;
    #1;
    check_fields("midrst", 32'd0, 6'd0, 512'd0, 512'd0);
    chk("midrst out_valid", 512'(out_valid), 512'(0));
    chk("midrst err_o", 512'(err_o), 512'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    send_vec(vecs[0], 0);
    check_vec("after rst", vecs[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
